mio_bus_ctrl: RTL

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

---
 rtl/mio_bus_ctrl_pkg.sv | 29 ++
 rtl/mio_lane_ext.sv | 19 +
 rtl/mio_bus_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mio_bus_ctrl_pkg.sv
// mio_bus_ctrl_pkg: shared control encodings (FSM states, access sizes, extension/ALU op codes) and access legality helper
package mio_bus_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR  = 3'd3
  } mio_state_e;
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mio_size_e;
  typedef enum logic [0:0] {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_op_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    return (size == SZ_H && a[0]) || (size == SZ_W && a[1:0] != 2'b00) || (size == SZ_D && a != 3'b000);
  endfunction
endpackage

// File: rtl/mio_lane_ext.sv
// mio_lane_ext: extracts the addressed load lane from data_in and sign/zero-extends it into rdata (ports: data_in, size, sext, off, rdata)
module mio_lane_ext import mio_bus_ctrl_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            data_in,
  input  logic [1:0]                   size,
  input  logic                         sext,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  output logic [DATA_W-1:0]            rdata
);
  logic [DATA_W-1:0] sh, m;
  logic msb;
  always_comb begin
    sh = data_in >> {off, 3'b000};
    m = size == SZ_B ? DATA_W'(8'hFF) : size == SZ_H ? DATA_W'(16'hFFFF) : size == SZ_W ? DATA_W'(32'hFFFF_FFFF) : '1;
    msb = size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : sh[DATA_W-1];
    rdata = (sh & m) | ((sext == EXT_SIGN && msb) ? ~m : '0);
  end
endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU-to-MIO bus FSM (cpu_* request side, Addr_out/Data_out/Data_in/mem_w/byte_en/CPU_MIO/MIO_ready bus side, busy/state debug) with timeout abort
module mio_bus_ctrl import mio_bus_ctrl_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [1:0]          cpu_size,
  input  logic                cpu_sext,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   Addr_out,
  output logic [DATA_W-1:0]   Data_out,
  input  logic [DATA_W-1:0]   Data_in,
  output logic                mem_w,
  output logic [DATA_W/8-1:0] byte_en,
  output logic                CPU_MIO,
  input  logic                MIO_ready,
  output logic [2:0]          state
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  mio_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic we_q, we_d, sext_q, sext_d, mem_w_q, mem_w_d, cio_q, cio_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, dout_q, dout_d, ext;
  logic [NB-1:0] be_q, be_d, m;
  logic bad;
  mio_lane_ext #(.DATA_W(DATA_W)) u_ext (
    .data_in(Data_in),
    .size(size_q),
    .sext(sext_q),
    .off(addr_q[LW-1:0]),
    .rdata(ext)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    we_d = we_q;
    size_d = size_q;
    sext_d = sext_q;
    rdata_d = rdata_q;
    dout_d = dout_q;
    be_d = '0;
    mem_w_d = 1'b0;
    cio_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    m = cpu_size == SZ_B ? NB'(1) : cpu_size == SZ_H ? NB'(3) : cpu_size == SZ_W ? NB'(15) : '1;
    bad = (cpu_size == SZ_D && DATA_W != 64) || misaligned(cpu_size, cpu_addr[2:0]);
    case (state_q)
      ST_IDLE:
        if (cpu_req && bad) begin
          state_d = ST_ERR;
          done_d = 1'b1;
          err_d = 1'b1;
        end else if (cpu_req) begin
          state_d = ST_REQ;
          cnt_d = '0;
          addr_d = cpu_addr;
          we_d = cpu_we;
          size_d = cpu_size;
          sext_d = cpu_sext;
          be_d = m << cpu_addr[LW-1:0];
          mem_w_d = cpu_we;
          cio_d = 1'b1;
          dout_d = cpu_size == SZ_B ? {NB{cpu_wdata[7:0]}} : cpu_size == SZ_H ? {(NB/2){cpu_wdata[15:0]}} :
                   cpu_size == SZ_W ? {(NB/4){cpu_wdata[31:0]}} : cpu_wdata;
        end
      ST_REQ:
        if (MIO_ready) begin
          state_d = ST_DONE;
          done_d = 1'b1;
          rdata_d = we_q ? rdata_q : ext;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          done_d = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          be_d = be_q;
          mem_w_d = mem_w_q;
          cio_d = 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      size_q <= '0;
      sext_q <= 1'b0;
      rdata_q <= '0;
      dout_q <= '0;
      be_q <= '0;
      mem_w_q <= 1'b0;
      cio_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      size_q <= size_d;
      sext_q <= sext_d;
      rdata_q <= rdata_d;
      dout_q <= dout_d;
      be_q <= be_d;
      mem_w_q <= mem_w_d;
      cio_q <= cio_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign cpu_rdata = rdata_q;
  assign cpu_done = done_q;
  assign cpu_err = err_q;
  assign busy = state_q != ST_IDLE;
  assign Addr_out = addr_q;
  assign Data_out = dout_q;
  assign mem_w = mem_w_q;
  assign byte_en = be_q;
  assign CPU_MIO = cio_q;
  assign state = state_q;
endmodule
